// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one sram-like bus between instruction fetch (I) and data (D) requesters
// Ports: clk, resetn (async, active-low); inst_*/data_* requester-side sram ports;
//   bus_* downstream sram port; proto_err sticky flag for bus_data_ok with nothing outstanding.
// Optional: define ARB_PERF_CNT_EN to add perf_inst_grants, perf_data_grants, perf_full_stall counters.
module mem_bus_arbiter #(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        proto_err
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_inst_grants,
  output logic [31:0] perf_data_grants,
  output logic [31:0] perf_full_stall
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  typedef enum logic {ARB, HOLD} state_t;
  state_t state, state_nx;
  logic hold_id, gnt_id, gnt_v, force_i, full, push, pop, head;
  logic [AW:0] count;
  logic [AW-1:0] wp, rp;
  logic [SW-1:0] starve_cnt;
  logic fifo [DEPTH];
  assign full = count == (AW+1)'(DEPTH);
  assign force_i = STARVE_LIMIT != 0 && starve_cnt == SW'(STARVE_LIMIT) && inst_req;
  // HOLD keeps the grant on the requester waiting for addr_ok; full cannot occur there
  always_comb begin
    state_nx = state;
    gnt_id = hold_id;
    gnt_v = 1'b0;
    if (state == HOLD) begin
      gnt_v = hold_id ? data_req : inst_req;
      if (!gnt_v || bus_addr_ok) state_nx = ARB;
    end else if (!full) begin
      gnt_id = !force_i && data_req;
      gnt_v = force_i || data_req || inst_req;
      if (gnt_v && !bus_addr_ok) state_nx = HOLD;
    end
  end
  assign bus_req = gnt_v & resetn;
  assign push = bus_req & bus_addr_ok;
  assign pop = bus_data_ok & (count != '0) & resetn;
  assign head = fifo[rp];
  assign inst_addr_ok = push & !gnt_id;
  assign data_addr_ok = push & gnt_id;
  assign inst_data_ok = pop & !head;
  assign data_data_ok = pop & head;
  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;
  assign bus_wr = gnt_id ? data_wr : inst_wr;
  assign bus_size = gnt_id ? data_size : inst_size;
  assign bus_wstrb = gnt_id ? data_wstrb : inst_wstrb;
  assign bus_addr = gnt_id ? data_addr : inst_addr;
  assign bus_wdata = gnt_id ? data_wdata : inst_wdata;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= ARB;
      hold_id <= 1'b0;
      count <= '0;
      wp <= '0;
      rp <= '0;
      starve_cnt <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ARB) hold_id <= gnt_id;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (bus_data_ok && count == '0) proto_err <= 1'b1;
      if (push && !gnt_id) starve_cnt <= '0;
      else if (push && inst_req && starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) fifo[wp] <= gnt_id;
`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      perf_inst_grants <= '0;
      perf_data_grants <= '0;
      perf_full_stall <= '0;
    end else begin
      if (inst_addr_ok) perf_inst_grants <= perf_inst_grants + 32'd1;
      if (data_addr_ok) perf_data_grants <= perf_data_grants + 32'd1;
      if ((inst_req || data_req) && full && state == ARB) perf_full_stall <= perf_full_stall + 32'd1;
    end
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and random checks of mem_bus_arbiter against a transaction-level model
module tb_mem_bus_arbiter;
  localparam int DEPTH = 4;
  localparam int LIM = 3;
  logic clk = 1'b0, resetn = 1'b0;
  logic inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
  logic [1:0] inst_size = 0, data_size = 0;
  logic [3:0] inst_wstrb = 0, data_wstrb = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic bus_req, bus_wr;
  logic [1:0] bus_size;
  logic [3:0] bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic bus_addr_ok = 0, bus_data_ok = 0;
  logic [31:0] bus_rdata = 0;
  logic proto_err;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_inst_grants, perf_data_grants, perf_full_stall;
`endif
  always #5 clk = ~clk;
  mem_bus_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .proto_err(proto_err)
`ifdef ARB_PERF_CNT_EN
    , .perf_inst_grants(perf_inst_grants), .perf_data_grants(perf_data_grants),
    .perf_full_stall(perf_full_stall)
`endif
  );
  int n_cmp = 0, n_err = 0;
  bit q[$];
  int starve = 0, held = -1;
  bit perr = 0, ihs = 0, dhs = 0;
  logic [7:0] order;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    starve = 0;
    held = -1;
    perr = 0;
    ihs = 0;
    dhs = 0;
  endtask
  // one bus cycle: inputs are already set; predict, compare at mid-cycle, then advance the model
  task automatic cyc();
    bit v, g, pop, hd;
    @(negedge clk);
    #1;
    if (held >= 0) begin
      g = held[0];
      v = g ? data_req : inst_req;
    end else if (q.size() == DEPTH) begin
      g = 0;
      v = 0;
    end else if (LIM != 0 && starve == LIM && inst_req) begin
      g = 0;
      v = 1;
    end else begin
      g = data_req;
      v = data_req | inst_req;
    end
    chk("bus_req", bus_req, v);
    chk("inst_addr_ok", inst_addr_ok, v & !g & bus_addr_ok);
    chk("data_addr_ok", data_addr_ok, v & g & bus_addr_ok);
    if (v) begin
      chk("bus_addr", bus_addr, g ? data_addr : inst_addr);
      chk("bus_wdata", bus_wdata, g ? data_wdata : inst_wdata);
      chk("bus_ctl", {bus_wr, bus_size, bus_wstrb},
          g ? {data_wr, data_size, data_wstrb} : {inst_wr, inst_size, inst_wstrb});
    end
    pop = bus_data_ok && q.size() > 0;
    hd = pop ? q[0] : 1'b0;
    chk("inst_data_ok", inst_data_ok, pop & !hd);
    chk("data_data_ok", data_data_ok, pop & hd);
    if (pop) chk("rdata", hd ? data_rdata : inst_rdata, bus_rdata);
    chk("proto_err", proto_err, perr);
    if (bus_data_ok && q.size() == 0) perr = 1;
    if (pop) void'(q.pop_front());
    ihs = v && bus_addr_ok && !g;
    dhs = v && bus_addr_ok && g;
    if (v && bus_addr_ok) begin
      q.push_back(g);
      starve = !g ? 0 : (inst_req && starve < LIM) ? starve + 1 : starve;
      held = -1;
    end else held = v ? int'(g) : -1;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    resetn = 0;
    inst_req = 0;
    data_req = 0;
    bus_addr_ok = 0;
    bus_data_ok = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
    resetn = 1;
  endtask
  task automatic new_inst();
    inst_addr = $urandom;
    inst_wdata = $urandom;
    inst_wr = 1'($urandom);
    inst_size = 2'($urandom);
    inst_wstrb = 4'($urandom);
  endtask
  task automatic new_data();
    data_addr = $urandom;
    data_wdata = $urandom;
    data_wr = 1'($urandom);
    data_size = 2'($urandom);
    data_wstrb = 4'($urandom);
  endtask
  // compliant requesters that hold until accepted, with rare illegal withdrawals
  task automatic rand_drive(input int pdok);
    if (ihs || !inst_req) begin
      inst_req = $urandom_range(99) < 50;
      new_inst();
    end else if ($urandom_range(99) < 3) inst_req = 0;
    if (dhs || !data_req) begin
      data_req = $urandom_range(99) < 50;
      new_data();
    end else if ($urandom_range(99) < 3) data_req = 0;
    bus_addr_ok = $urandom_range(99) < 60;
    bus_data_ok = q.size() > 0 && $urandom_range(99) < pdok;
    bus_rdata = $urandom;
  endtask
  initial begin
    do_reset();
    inst_req = 1;
    inst_addr = 32'h1FC00000;
    bus_addr_ok = 1;
    cyc();
    inst_req = 0;
    bus_addr_ok = 0;
    bus_data_ok = 1;
    bus_rdata = 32'h3C080000;
    @(negedge clk);
    chk("boot_inst_data_ok", inst_data_ok, 1);
    chk("boot_inst_rdata", inst_rdata, 32'h3C080000);
    @(posedge clk);
    #1;
    model_reset_q_pop: if (q.size() > 0) void'(q.pop_front());
    bus_data_ok = 0;
    inst_req = 1;
    data_req = 1;
    bus_addr_ok = 1;
    order = 0;
    for (int i = 0; i < 8; i++) begin
      bus_data_ok = q.size() > 0;
      new_inst();
      new_data();
      cyc();
      order = {order[6:0], dhs};
    end
    chk("grant_order", order, 8'hEE);
    inst_req = 0;
    data_req = 0;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      bus_data_ok = 1;
      cyc();
    end
    chk("drained", q.size(), 0);
    bus_data_ok = 0;
    bus_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      data_req = i != 1;
      inst_req = i == 1;
      new_inst();
      new_data();
      cyc();
    end
    inst_req = 0;
    data_req = 1;
    new_data();
    cyc();
    bus_data_ok = 1;
    cyc();
    chk("full_pop_no_grant", dhs, 0);
    bus_data_ok = 0;
    cyc();
    chk("grant_after_pop", dhs, 1);
    chk("count_refilled", q.size(), 4);
    data_req = 0;
    bus_data_ok = 1;
    for (int i = 0; i < 4; i++) cyc();
    bus_data_ok = 1;
    cyc();
    bus_data_ok = 0;
    cyc();
    chk("proto_err_sticky", perr, 1);
    data_req = 1;
    bus_addr_ok = 0;
    new_data();
    cyc();
    #2 resetn = 0;
    #1;
    chk("async_rst_proto_err", proto_err, 0);
    chk("async_rst_bus_req", bus_req, 0);
    model_reset();
    @(posedge clk);
    #1;
    data_req = 0;
    inst_req = 1;
    bus_addr_ok = 1;
    new_inst();
    resetn = 1;
    cyc();
    chk("post_rst_inst_grant", ihs, 1);
    inst_req = 0;
    for (int i = 0; i < 1500; i++) begin
      rand_drive(70);
      cyc();
    end
    for (int i = 0; i < 1500; i++) begin
      rand_drive(20);
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
